register_manager: RTL

- Consumer end of the write-back interface: accepts result/rd/result_v from write_back and commits them to the architectural integer register file.
- Owns a per-register scoreboard of pending writes.
- Serves the issue/decode stage with two combinational read ports (write-back bypass) and a hazard handshake that stalls issue on RAW/WAW conflicts.

---
 rtl/register_manager.sv | 127 ++++++++++++
 1 files changed

// File: rtl/register_manager.sv
// register_manager: architectural integer register file with write-back commit,
// a per-register scoreboard of pending writes, two bypassed combinational read
// ports and a RAW/WAW hazard handshake for the issue stage. x0 reads as zero,
// is never written and is never reserved.
module register_manager #(
  parameter int xlen = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [xlen-1:0] result,
  input  logic [4:0]      rd,
  input  logic            result_v,
  input  logic            issue_v,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_v,
  output logic            issue_ready,
  output logic [xlen-1:0] rs1_data,
  output logic [xlen-1:0] rs2_data,
  output logic [NREG-1:0] busy_mask,
  output logic            wb_unexpected
);

  logic [xlen-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] commit_dec;
  logic [NREG-1:0] reserve_dec;
  logic            commit_en;
  logic            rs1_haz;
  logic            rs2_haz;
  logic            waw_haz;
  logic            issue_fire;
  logic            unexpected_now;

  // One-hot decode of a register index; x0 never decodes, so it can neither be
  // committed nor reserved.
  function automatic logic [NREG-1:0] decode(input logic [4:0] idx, input logic en);
    logic [NREG-1:0] d;
    d = '0;
    for (int r = 1; r < NREG; r++) begin
      if (en && (idx == 5'(r))) d[r] = 1'b1;
    end
    return d;
  endfunction

  // A source is hazardous only if it is reserved and not being retired by the
  // write-back arriving in this very cycle (that value is bypassed instead).
  function automatic logic src_hazard(input logic [4:0] sel,
                                      input logic [NREG-1:0] bsy,
                                      input logic [NREG-1:0] cdec);
    return bsy[sel] && !cdec[sel];
  endfunction

  // Commit decode is shared by bypass, hazard masking and scoreboard clear.
  always_comb begin
    commit_en  = result_v && (rd != 5'd0);
    commit_dec = decode(rd, result_v);
  end

  // Read port 1: x0 is zero, in-flight write-back wins over the stored value.
  always_comb begin
    rs1_data = regs[issue_rs1];
    if (issue_rs1 == 5'd0)
      rs1_data = '0;
    else if (result_v && (rd == issue_rs1))
      rs1_data = result;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data = regs[issue_rs2];
    if (issue_rs2 == 5'd0)
      rs2_data = '0;
    else if (result_v && (rd == issue_rs2))
      rs2_data = result;
  end

  // Hazard detection; deliberately independent of issue_v so the issue stage
  // can look at issue_ready before deciding to present an instruction.
  always_comb begin
    rs1_haz     = src_hazard(issue_rs1, busy, commit_dec);
    rs2_haz     = src_hazard(issue_rs2, busy, commit_dec);
    waw_haz     = issue_rd_v && src_hazard(issue_rd, busy, commit_dec);
    issue_ready = !(rs1_haz || rs2_haz || waw_haz);
    issue_fire  = issue_v && issue_ready && issue_rd_v;
  end

  // Next scoreboard: a reservation in the same cycle as a commit to the same
  // register wins, because the new writer is still outstanding.
  always_comb begin
    reserve_dec    = decode(issue_rd, issue_fire);
    busy_next      = (busy & ~commit_dec) | reserve_dec;
    busy_next[0]   = 1'b0;
    unexpected_now = commit_en && !busy[rd];
  end

  // Scoreboard register; reset discards every outstanding reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_next;
  end

  // Sticky flag for write-backs that had no matching reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_unexpected <= 1'b0;
    else if (unexpected_now)
      wb_unexpected <= 1'b1;
  end

  // Register file commit; an unexpected write-back is still committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit_en) begin
      regs[rd] <= result;
    end
  end

  assign busy_mask = busy;

endmodule
